// File: rtl/req_index_encoder.sv
// Round-robin request-to-index encoder.
// Sticky pending bits are collected from multi-hot request pulses and drained one
// index per valid/ready handshake. The search for the next index starts just
// above the most recently accepted one, so every pending bit is served fairly.
module req_index_encoder #(
  parameter int unsigned N_REQ = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             flush,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W:0]   pend_count,
  output logic [N_REQ-1:0] pending_q
);

  logic [IDX_W-1:0] ptr_q;
  logic             accept;
  logic             update;
  logic [N_REQ-1:0] clear_mask;
  logic [N_REQ-1:0] pending_next;
  logic [IDX_W-1:0] ptr_next;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W:0]   count_next;

  // Handshake, clear and next-pending computation; a same-cycle request wins over the clear.
  always_comb begin
    accept       = idx_valid & idx_ready;
    update       = ~idx_valid | idx_ready;
    clear_mask   = accept ? (N_REQ'(1) << idx_out) : '0;
    pending_next = (pending_q & ~clear_mask) | req_in;
    ptr_next     = accept ? (idx_out + IDX_W'(1)) : ptr_q;
  end

  // First set bit of pending_next at or above ptr_next, wrapping modulo N_REQ.
  always_comb begin
    logic [IDX_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ptr_next + IDX_W'(i);
      if (!sel_found && pending_next[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Popcount of the next pending vector, registered so it tracks pending_q exactly.
  always_comb begin
    count_next = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      count_next = count_next + (IDX_W + 1)'(pending_next[i]);
    end
  end

  // State registers; flush beats both new requests and an accept in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      idx_out    <= '0;
      idx_valid  <= 1'b0;
      pend_count <= '0;
    end else if (flush) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      idx_out    <= '0;
      idx_valid  <= 1'b0;
      pend_count <= '0;
    end else begin
      pending_q  <= pending_next;
      ptr_q      <= ptr_next;
      pend_count <= count_next;
      // A presented index is never replaced until the consumer takes it.
      if (update) begin
        idx_valid <= |pending_next;
        if (sel_found) begin
          idx_out <= sel_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_req_index_encoder.sv
// Directed, table-driven bench for req_index_encoder.
module tb_req_index_encoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_in;
  logic        flush;
  logic [4:0]  idx_out;
  logic        idx_valid;
  logic        idx_ready;
  logic [5:0]  pend_count;
  logic [31:0] pending_q;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] req;
    logic        rdy;
    logic        fl;
    logic        v;
    logic [4:0]  idx;
    logic [5:0]  cnt;
    logic [31:0] pend;
    string       name;
  } vec_t;

  vec_t vecs[$];

  req_index_encoder #(
    .N_REQ(32),
    .IDX_W(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .flush     (flush),
    .idx_out   (idx_out),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .pend_count(pend_count),
    .pending_q (pending_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input logic v, input logic [4:0] idx,
                           input logic [5:0] cnt, input logic [31:0] pend);
    check({name, " valid"}, {31'd0, idx_valid}, {31'd0, v});
    check({name, " count"}, {26'd0, pend_count}, {26'd0, cnt});
    check({name, " pending"}, pending_q, pend);
    if (v) check({name, " idx"}, {27'd0, idx_out}, {27'd0, idx});
    else   check({name, " idx_hold"}, {27'd0, idx_out}, {27'd0, idx});
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic [31:0] r, input logic rdy, input logic fl);
    req_in    = r;
    idx_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic [31:0] r, input logic rdy, input logic fl,
                     input logic v, input logic [4:0] idx, input logic [5:0] cnt,
                     input logic [31:0] pend);
    vec_t t;
    t.name = n; t.req = r; t.rdy = rdy; t.fl = fl;
    t.v = v; t.idx = idx; t.cnt = cnt; t.pend = pend;
    vecs.push_back(t);
  endtask

  initial begin
    // name, req, rdy, flush | valid, idx, count, pending
    add("single",      32'h0000_0400, 1, 0, 1, 10, 1, 32'h0000_0400);
    add("single_done", 32'h0,         1, 0, 0, 10, 0, 32'h0);
    add("flush0",      32'h0,         0, 1, 0, 0,  0, 32'h0);
    add("rr_load",     32'h8000_0003, 1, 0, 1, 0,  3, 32'h8000_0003);
    add("rr_1",        32'h0,         1, 0, 1, 1,  2, 32'h8000_0002);
    add("rr_31",       32'h0,         1, 0, 1, 31, 1, 32'h8000_0000);
    add("wrap_inj",    32'h4000_0001, 1, 0, 1, 0,  2, 32'h4000_0001);
    add("wrap_30",     32'h0,         1, 0, 1, 30, 1, 32'h4000_0000);
    add("wrap_empty",  32'h0,         1, 0, 0, 30, 0, 32'h0);
    add("bp_load2",    32'h0000_0004, 0, 0, 1, 2,  1, 32'h0000_0004);
    add("bp_acc2",     32'h0000_0024, 1, 0, 1, 5,  2, 32'h0000_0024);
    add("bp_hold1",    32'h0,         0, 0, 1, 5,  2, 32'h0000_0024);
    add("bp_req4",     32'h0000_0010, 0, 0, 1, 5,  3, 32'h0000_0034);
    add("bp_hold3",    32'h0,         0, 0, 1, 5,  3, 32'h0000_0034);
    add("bp_hold4",    32'h0,         0, 0, 1, 5,  3, 32'h0000_0034);
    add("bp_seq2",     32'h0,         1, 0, 1, 2,  2, 32'h0000_0014);
    add("bp_seq4",     32'h0,         1, 0, 1, 4,  1, 32'h0000_0010);
    add("bp_empty",    32'h0,         1, 0, 0, 4,  0, 32'h0);
    add("sw_load",     32'h0000_0280, 0, 0, 1, 7,  2, 32'h0000_0280);
    add("sw_collide",  32'h0000_0080, 1, 0, 1, 9,  2, 32'h0000_0280);
    add("sw_reemit",   32'h0,         1, 0, 1, 7,  1, 32'h0000_0080);
    add("sw_empty",    32'h0,         1, 0, 0, 7,  0, 32'h0);
    add("flush1",      32'h0,         0, 1, 0, 0,  0, 32'h0);
    add("full",        32'hFFFF_FFFF, 1, 0, 1, 0,  32, 32'hFFFF_FFFF);
    add("full_nostack",32'hFFFF_FFFF, 0, 0, 1, 0,  32, 32'hFFFF_FFFF);

    rst_n = 1'b0; req_in = '0; flush = 1'b0; idx_ready = 1'b0;
    #2;
    check_all("reset", 0, 0, 0, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in mid-cycle with work pending.
    step(32'h0000_00F0, 0, 0);
    check_all("pre_rst", 1, 4, 4, 32'h0000_00F0);
    #3 rst_n = 1'b0;
    #1 check_all("async_rst", 0, 0, 0, 32'h0);
    #2 rst_n = 1'b1;
    step(32'h0, 1, 0);
    check_all("idle", 0, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].rdy, vecs[i].fl);
      check_all(vecs[i].name, vecs[i].v, vecs[i].idx, vecs[i].cnt, vecs[i].pend);
    end

    // Drain the full register in order 0..31, one per cycle.
    for (int k = 1; k < 32; k++) begin
      step(32'h0, 1, 0);
      check_all($sformatf("drain_%0d", k), 1, 5'(k), 6'(32 - k), 32'hFFFF_FFFF << k);
    end
    step(32'h0, 1, 0);
    check_all("drain_end", 0, 31, 0, 32'h0);

    // Refill, then flush against a simultaneous request and accept.
    step(32'hFFFF_FFFF, 1, 0);
    check_all("refill", 1, 0, 32, 32'hFFFF_FFFF);
    step(32'h0000_0001, 1, 1);
    check_all("flush_prio", 0, 0, 0, 32'h0);
    // Pointer must be back at 0: bit 0 wins over bit 31.
    step(32'h8000_0001, 0, 0);
    check_all("ptr_zero", 1, 0, 2, 32'h8000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
